// File: rtl/hbs_pkg.sv
// Shared constants and helpers for the high-bit search unit and its priority tree.
// Latency: n/a (compile-time only). Backpressure: n/a.
// Optional one-hot output is controlled by HBS_ONEHOT_OUT_EN in the top level.
package hbs_pkg;

   localparam int HBS_MAX_WIDTH = 1024;

   // A 1-bit-wide tree leaf still needs a 1-bit index port.
   function automatic int idx_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/high_bit_search_unit_if.sv
// Bundle of the search unit's data word and registered results; master drives the word.
// Latency: n/a (wiring only). Backpressure: none, a word is accepted every cycle.
// high_bit_onehot exists only when HBS_ONEHOT_OUT_EN is defined.
interface high_bit_search_unit_if #(
   parameter int INPUT_WIDTH = 16,
   parameter int IDX_WIDTH   = $clog2(INPUT_WIDTH)
);

   logic [INPUT_WIDTH-1:0] input_data;
   logic [IDX_WIDTH-1:0]   high_bit_idx;
   logic                   found;
`ifdef HBS_ONEHOT_OUT_EN
   logic [INPUT_WIDTH-1:0] high_bit_onehot;
`endif

   modport master (
      output input_data,
      input  high_bit_idx,
      input  found
`ifdef HBS_ONEHOT_OUT_EN
      ,
      input  high_bit_onehot
`endif
   );

   modport slave (
      input  input_data,
      output high_bit_idx,
      output found
`ifdef HBS_ONEHOT_OUT_EN
      ,
      output high_bit_onehot
`endif
   );

endinterface

// File: rtl/hbs_prio_tree.sv
// Combinational leading-one finder built as a recursive halving tree, upper half wins.
// Latency: 0 cycles, depth ceil(log2 WIDTH) merge levels. Backpressure: none.
// Not affected by HBS_ONEHOT_OUT_EN.
module hbs_prio_tree
   import hbs_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0]            data,
   output logic [idx_width(WIDTH)-1:0] idx,
   output logic                        any
);

   localparam int IDX_W = idx_width(WIDTH);

   generate
      if (WIDTH == 1) begin : g_leaf
         assign idx = '0;
         assign any = data[0];
      end else begin : g_node
         // Lower half is a power of two, so upper-half indices are a plain offset
         // and padding above WIDTH never exists in the tree.
         localparam int LO_W  = 2 ** ($clog2(WIDTH) - 1);
         localparam int HI_W  = WIDTH - LO_W;
         localparam int LO_IW = idx_width(LO_W);
         localparam int HI_IW = idx_width(HI_W);

         logic [LO_IW-1:0] lo_idx;
         logic [HI_IW-1:0] hi_idx;
         logic             lo_any;
         logic             hi_any;

         hbs_prio_tree #(.WIDTH(LO_W)) u_lo (
            .data (data[LO_W-1:0]),
            .idx  (lo_idx),
            .any  (lo_any)
         );

         hbs_prio_tree #(.WIDTH(HI_W)) u_hi (
            .data (data[WIDTH-1:LO_W]),
            .idx  (hi_idx),
            .any  (hi_any)
         );

         assign any = hi_any | lo_any;
         assign idx = hi_any ? (IDX_W'(LO_W) + IDX_W'(hi_idx)) : IDX_W'(lo_idx);
      end
   endgenerate

endmodule

// File: rtl/high_bit_search_unit.sv
// Registered most-significant-set-bit finder; optional one-hot result via HBS_ONEHOT_OUT_EN.
// Latency: 1 cycle, one word per cycle. Backpressure: none, input sampled every edge.
// Async active-high rst clears all outputs immediately.
module high_bit_search_unit
   import hbs_pkg::*;
#(
   parameter int INPUT_WIDTH = 16,
   parameter int IDX_WIDTH   = $clog2(INPUT_WIDTH)
) (
   input logic                    clk,
   input logic                    rst,
   high_bit_search_unit_if.slave  hbs
);

   generate
      if (INPUT_WIDTH < 2 || INPUT_WIDTH > HBS_MAX_WIDTH) begin : g_bad_width
         $error("high_bit_search_unit: INPUT_WIDTH out of range");
      end
   endgenerate

   logic [IDX_WIDTH-1:0] tree_idx;
   logic                 tree_any;
   logic [IDX_WIDTH-1:0] idx_q;
   logic                 found_q;

   hbs_prio_tree #(.WIDTH(INPUT_WIDTH)) u_tree (
      .data (hbs.input_data),
      .idx  (tree_idx),
      .any  (tree_any)
   );

   // Tree already reports 0 for an all-zero word, so the index needs no masking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q   <= '0;
         found_q <= 1'b0;
      end else begin
         idx_q   <= tree_idx;
         found_q <= tree_any;
      end
   end

   assign hbs.high_bit_idx = idx_q;
   assign hbs.found        = found_q;

`ifdef HBS_ONEHOT_OUT_EN
   logic [INPUT_WIDTH-1:0] onehot_nxt;
   logic [INPUT_WIDTH-1:0] onehot_q;

   always_comb begin
      onehot_nxt = '0;
      if (tree_any) begin
         onehot_nxt = INPUT_WIDTH'(1) << tree_idx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         onehot_q <= '0;
      end else begin
         onehot_q <= onehot_nxt;
      end
   end

   assign hbs.high_bit_onehot = onehot_q;
`endif

endmodule

// File: tb/tb_high_bit_search_unit.sv
// Directed and randomised bench for high_bit_search_unit at widths 16, 2, 5 and 33.
// One-hot output is also checked when HBS_ONEHOT_OUT_EN is defined.
module tb_high_bit_search_unit;

   logic clk = 1'b0;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   high_bit_search_unit_if #(.INPUT_WIDTH(16)) bus16 ();
   high_bit_search_unit_if #(.INPUT_WIDTH(2))  bus2  ();
   high_bit_search_unit_if #(.INPUT_WIDTH(5))  bus5  ();
   high_bit_search_unit_if #(.INPUT_WIDTH(33)) bus33 ();

   high_bit_search_unit #(.INPUT_WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .hbs(bus16));
   high_bit_search_unit #(.INPUT_WIDTH(2))  u_dut2  (.clk(clk), .rst(rst), .hbs(bus2));
   high_bit_search_unit #(.INPUT_WIDTH(5))  u_dut5  (.clk(clk), .rst(rst), .hbs(bus5));
   high_bit_search_unit #(.INPUT_WIDTH(33)) u_dut33 (.clk(clk), .rst(rst), .hbs(bus33));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: the MSB position of a non-zero value m is ceil(log2(m+1)) - 1.
   function automatic void ref_msb(input logic [63:0] d, input int w,
                                   output int idx, output bit fnd);
      logic [63:0] m;
      m   = d & ((64'd1 << w) - 64'd1);
      fnd = (m != 64'd0);
      idx = fnd ? ($clog2(m + 64'd1) - 1) : 0;
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk16(input string tag, input int eidx, input bit efound);
      chk({tag, "_idx"},   64'(bus16.high_bit_idx), 64'(eidx));
      chk({tag, "_found"}, 64'(bus16.found),        64'(efound));
`ifdef HBS_ONEHOT_OUT_EN
      chk({tag, "_onehot"}, 64'(bus16.high_bit_onehot),
          efound ? (64'd1 << eidx) : 64'd0);
`endif
   endtask

   // Checks one instance against the model for the word it was given last cycle.
   task automatic chk_model(input string tag, input logic [63:0] d, input int w,
                            input logic [63:0] obs_idx, input logic obs_found);
      int e_idx;
      bit e_fnd;
      ref_msb(d, w, e_idx, e_fnd);
      chk({tag, "_idx"},   obs_idx,          64'(e_idx));
      chk({tag, "_found"}, 64'(obs_found),   64'(e_fnd));
   endtask

   logic [15:0] stream_dat [10] = '{16'h16DE, 16'h5403, 16'h00BE, 16'h0F15, 16'h87CA,
                                    16'h0124, 16'h23BA, 16'hBF76, 16'h14DE, 16'h7643};
   int          stream_exp [10] = '{12, 14, 7, 11, 15, 8, 13, 15, 12, 14};

   initial begin
      logic [63:0] d2, d5, d16, d33;

      // Reset held with an all-ones word: outputs stay cleared with no clock edge needed.
      rst               = 1'b1;
      bus16.input_data  = 16'hFFFF;
      bus2.input_data   = 2'b11;
      bus5.input_data   = 5'h1F;
      bus33.input_data  = 33'h1_FFFF_FFFF;
      #1;
      chk16("rst_async", 0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk16($sformatf("rst_hold%0d", i), 0, 1'b0);
      end
      chk("rst_w33_found", 64'(bus33.found), 64'd0);

      rst = 1'b0;
      cycle();
      chk16("rst_release", 15, 1'b1);

      // Back-to-back stream, each result one edge after its word.
      for (int i = 0; i < 10; i++) begin
         bus16.input_data = stream_dat[i];
         cycle();
         chk16($sformatf("stream%0d", i), stream_exp[i], 1'b1);
      end

      bus16.input_data = 16'h0000;
      cycle();
      chk16("zero", 0, 1'b0);
      bus16.input_data = 16'h0001;
      cycle();
      chk16("bit0", 0, 1'b1);
      bus16.input_data = 16'h8000;
      cycle();
      chk16("bit15", 15, 1'b1);
      for (int p = 0; p < 16; p++) begin
         bus16.input_data = 16'(1) << p;
         cycle();
         chk16($sformatf("walk%0d", p), p, 1'b1);
      end

`ifdef HBS_ONEHOT_OUT_EN
      bus16.input_data = 16'h0F15;
      cycle();
      chk("onehot_0f15", 64'(bus16.high_bit_onehot), 64'h0800);
      bus16.input_data = 16'h0000;
      cycle();
      chk("onehot_zero", 64'(bus16.high_bit_onehot), 64'h0000);
`endif

      // Mid-stream reset between edges; the word shown during reset must vanish.
      bus16.input_data = 16'h0400;
      cycle();
      chk16("pre_rst", 10, 1'b1);
      #2;
      rst              = 1'b1;
      bus16.input_data = 16'hFFFF;
      #1;
      chk16("mid_rst_async", 0, 1'b0);
      cycle();
      chk16("mid_rst_hold", 0, 1'b0);
      rst              = 1'b0;
      bus16.input_data = 16'h0124;
      cycle();
      chk16("post_rst", 8, 1'b1);

      bus33.input_data = 33'h1_0000_0000;
      bus5.input_data  = 5'h00;
      bus2.input_data  = 2'b01;
      cycle();
      chk("w33_top_idx",   64'(bus33.high_bit_idx), 64'd32);
      chk("w33_top_found", 64'(bus33.found),        64'd1);
      chk("w5_zero_found", 64'(bus5.found),         64'd0);
      chk("w2_bit0_found", 64'(bus2.found),         64'd1);

      // Randomised sweep across all widths; roughly one word in eight is zero.
      for (int i = 0; i < 300; i++) begin
         d2  = 64'($urandom_range(0, 3));
         d5  = 64'($urandom_range(0, 31));
         d16 = 64'($urandom) & 64'hFFFF;
         d33 = {31'd0, 1'($urandom), 32'($urandom)};
         // Bias toward sparse words so low indices are exercised at wide widths.
         if ($urandom_range(0, 3) == 0) d33 = d33 >> $urandom_range(0, 32);
         if ($urandom_range(0, 7) == 0) d16 = 64'd0;
         if ($urandom_range(0, 7) == 0) d33 = 64'd0;
         if ($urandom_range(0, 7) == 0) d5  = 64'd0;
         bus2.input_data  = d2[1:0];
         bus5.input_data  = d5[4:0];
         bus16.input_data = d16[15:0];
         bus33.input_data = d33[32:0];
         cycle();
         chk_model($sformatf("rnd%0d_w2", i),  d2,  2,  64'(bus2.high_bit_idx),  bus2.found);
         chk_model($sformatf("rnd%0d_w5", i),  d5,  5,  64'(bus5.high_bit_idx),  bus5.found);
         chk_model($sformatf("rnd%0d_w16", i), d16, 16, 64'(bus16.high_bit_idx), bus16.found);
         chk_model($sformatf("rnd%0d_w33", i), d33, 33, 64'(bus33.high_bit_idx), bus33.found);
`ifdef HBS_ONEHOT_OUT_EN
         begin
            int e_idx;
            bit e_fnd;
            ref_msb(d33, 33, e_idx, e_fnd);
            chk($sformatf("rnd%0d_w33_onehot", i), 64'(bus33.high_bit_onehot),
                e_fnd ? (64'd1 << e_idx) : 64'd0);
         end
`endif
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/high_bit_search_unit.md
Name: high_bit_search_unit

Overview:
- Registered most-significant-set-bit (leading-one) finder for a parameterisable data word.
- Each rising clock edge it samples the input word and presents:
  - the index of the highest bit that is set;
  - a flag that is high when any bit is set.
- Sits in datapaths as a normalisation / priority helper, e.g. for leading-zero counts and arbitration.

Parameters:
- INPUT_WIDTH, default 16: width of the input word; legal range 2..1024.
- IDX_WIDTH, default $clog2(INPUT_WIDTH): derived width of the index output; do not override.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- input_data  input  INPUT_WIDTH  word to search; sampled every rising edge, no handshake.
- high_bit_idx  output  IDX_WIDTH  registered index of the most significant '1' in the sampled word.
- found  output  1  registered; 1 when the sampled word was non-zero.

Behaviour:
- Reset:
  - rst high forces high_bit_idx = 0 and found = 0 immediately, without waiting for a clock edge.
  - Both outputs hold these values while rst is high.
  - The first sample is taken at the first rising edge after rst deasserts.
- Latency: 1 cycle.
  - input_data present at rising edge N produces outputs valid after edge N.
  - The outputs hold until edge N+1.
- Throughput: one new word per cycle, fully pipelined, no stalls.
- Encoding: high_bit_idx = the largest i such that input_data[i] == 1. Bit 0 is the LSB.
- All-zero input: found = 0 and high_bit_idx = 0. Consumers must qualify the index with found.
- Single-bit input: a word with only bit 0 set gives found = 1 and high_bit_idx = 0. This is distinguishable from all-zero only by found.
- Full input (all ones): high_bit_idx = INPUT_WIDTH-1, found = 1.
- Non-power-of-two widths: the index refers to the real bit position. Implicit padding bits are treated as zero and are never reported.
- Implementation structure:
  - Combinational search as a balanced binary priority tree; depth is ceil(log2 INPUT_WIDTH).
  - Each tree node merges its two halves with the upper half taking priority.
  - A linear loop is not permitted.
  - Only the final result is registered.
- Reset mid-stream:
  - Asserting rst clears the outputs at once.
  - The value present on input_data during reset is discarded.
- No X propagation: if any bit of input_data is X, the output is unspecified, but it must not corrupt later cycles.

Optional Feature:
- Macro HBS_ONEHOT_OUT_EN.
- When defined:
  - Adds output port high_bit_onehot, width INPUT_WIDTH, registered alongside the other outputs.
  - It has exactly one bit set, at position high_bit_idx, when found = 1, and is all zeros otherwise.
  - It resets to 0.
- When undefined: the port and its register do not exist. Behaviour of the remaining ports is identical.

Decomposition:
- Shared package hbs_pkg:
  - a constant function for the index width (clog2 with a minimum of 1);
  - a localparam for the maximum supported width.
- Sub-module hbs_prio_tree:
  - purely combinational;
  - parameter WIDTH;
  - ports: data in, idx out, any out;
  - recursive or generate-based halving tree.
- The top level instantiates hbs_prio_tree once and adds the output registers, reset and optional one-hot decode.

Test Plan:
- Reset: hold rst high with input_data = 16'hFFFF -> found = 0 and high_bit_idx = 0 throughout. Release -> next edge gives idx 15, found 1.
- Stream back-to-back, one word per cycle; each result appears one cycle after its word:
  - 16'h16DE -> 12, 16'h5403 -> 14, 16'h00BE -> 7, 16'h0F15 -> 11, 16'h87CA -> 15;
  - 16'h0124 -> 8, 16'h23BA -> 13, 16'hBF76 -> 15, 16'h14DE -> 12, 16'h7643 -> 14;
  - all with found = 1.
- Boundaries:
  - 16'h0000 -> found 0, idx 0;
  - 16'h0001 -> found 1, idx 0;
  - 16'h8000 -> idx 15;
  - walking-one over all 16 positions -> idx equals the position.
- Asynchronous reset mid-stream: assert rst between edges while found = 1 -> outputs clear before the next edge. The word presented during reset produces no result.
- Parameter sweep: INPUT_WIDTH = 2, 5, 33. Randomised words compared against a reference model; 33'h1_0000_0000 -> idx 32. An all-zero word always gives found 0.
- With HBS_ONEHOT_OUT_EN: 16'h0F15 -> high_bit_onehot = 16'h0800; 16'h0000 -> 16'h0000.
